// File: rtl/fir_decimator.sv
// Block-average decimator: sums DECIM input samples, emits the floored mean
// into a small output FIFO with sticky overflow reporting.
module fir_decimator #(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [4:0]  fifo_level,
  output logic        overflow
);

  localparam int         SH       = $clog2(DECIM);
  localparam int         PW       = $clog2(FIFO_DEPTH);
  localparam logic [3:0] CNT_LAST = 4'(DECIM - 1);
  localparam logic [4:0] LVL_FULL = 5'(FIFO_DEPTH);

  logic [19:0]   acc_q, acc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   mem_q [FIFO_DEPTH];

  logic [19:0] sum;
  logic [15:0] result;
  logic        push, pop, full, wr_en;

  always_comb begin
    sum    = acc_q + {{4{in_data[15]}}, in_data};
    result = 16'($signed(sum) >>> SH);
    push   = in_valid & ~flush & (cnt_q == CNT_LAST);
    pop    = (level_q != 5'd0) & out_ready;
    full   = (level_q == LVL_FULL);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    wr_en  = push & (~full | pop);

    acc_d      = acc_q;
    cnt_d      = cnt_q;
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_valid) begin
      if (cnt_q == CNT_LAST) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 4'd1;
      end
    end

    wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d    = level_q + {4'd0, wr_en} - {4'd0, pop};
    overflow_d = overflow_q | (push & full & ~pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= result;
  end

  assign out_valid  = (level_q != 5'd0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : 16'd0;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001: Parameter DECIM, default 4, decimation ratio; SHALL be one of 2, 4, 8, 16.
REQ-002: Parameter FIFO_DEPTH, default 4, number of output FIFO entries; SHALL be a power of two, 2..16.
REQ-003: clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: in_valid  input  1  qualifies in_data as one filtered sample.
REQ-006: in_data  input  16  signed sample from the upstream FIR filter output.
REQ-007: flush  input  1  synchronous; discards the partial block.
REQ-008: out_valid  output  1  FIFO head holds a decimated result.
REQ-009: out_ready  input  1  downstream accepts out_data this cycle.
REQ-010: out_data  output  16  signed decimated result at the FIFO head.
REQ-011: fifo_level  output  5  number of results currently stored, 0..FIFO_DEPTH.
REQ-012: overflow  output  1  sticky flag: a result was dropped.

Function
REQ-013: Block SHALL hold a 20-bit signed accumulator ACC and a 4-bit sample counter CNT, range 0..DECIM-1.
REQ-014: Cycles with in_valid=0 SHALL leave ACC and CNT unchanged.
REQ-015: On in_valid=1 with CNT<DECIM-1: ACC <= ACC + sign-extended in_data, and CNT <= CNT+1.
REQ-016: On in_valid=1 with CNT=DECIM-1: result = (ACC + in_data) arithmetic-shifted right by log2(DECIM), truncated to 16 bits; ACC <= 0; CNT <= 0; result is pushed to the FIFO in the same edge.
REQ-017: Rounding SHALL be floor (toward negative infinity); no saturation is needed because the block average always fits 16 bits.
REQ-018: Latency: out_valid SHALL rise the cycle after the edge that captures the DECIM-th sample, provided the FIFO was empty.
REQ-019: FIFO SHALL be first-in first-out; out_data SHALL equal the oldest entry whenever out_valid=1.
REQ-020: out_valid SHALL equal (fifo_level != 0).
REQ-021: Pop SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-022: out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023: Push and pop on the same edge SHALL both take effect, leaving fifo_level unchanged; this SHALL apply even when the FIFO is full.
REQ-024: A push when fifo_level=FIFO_DEPTH with no simultaneous pop SHALL drop the new result, leave FIFO contents unchanged, and set overflow=1.
REQ-025: overflow SHALL stay set until reset.
REQ-026: flush=1 SHALL set ACC <= 0 and CNT <= 0, and SHALL suppress any push in that cycle even if in_valid=1 with CNT=DECIM-1; the FIFO and overflow SHALL be unaffected.
REQ-027: out_ready with an empty FIFO SHALL have no effect; fifo_level SHALL never underflow.
REQ-028: Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029: reset=1 SHALL immediately set ACC=0, CNT=0, FIFO empty (pointers 0, fifo_level=0), out_valid=0, out_data=0, overflow=0, regardless of clk.
REQ-030: Reset asserted mid-block SHALL discard the partial block; the first in_valid sample after release SHALL start a new block at CNT=0.

Verification
REQ-031: DECIM=4, out_ready=1, samples 100,200,300,400 on consecutive cycles -> one out_valid pulse one cycle after the 4th edge, out_data=250.
REQ-032: Rounding and extremes: samples -1,-2,-2,-2 -> -2 (sum -7 floored); 4x32767 -> 32767; 4x(-32768) -> -32768.
REQ-033: Gaps: samples 8,_,_,8,8,_,8 (where _ is in_valid=0) -> single result 8; gap cycles do not advance CNT.
REQ-034: Backpressure: out_ready=0, five full blocks of constants 1..5 -> fifo_level=4, overflow=1; then out_ready=1 drains 1,2,3,4 in order, and 5 never appears.
REQ-035: Full FIFO with out_ready=1 on the completing edge -> head popped and new result stored, fifo_level stays 4, overflow stays 0.
REQ-036: Reset after 2 of 4 samples (and, separately, flush after 3) -> all outputs 0 after reset; the next 4 samples 40 each -> out_data=40.
